// File: rtl/mel_pkg.sv
// Shared definitions for the mel filterbank datapath: sequencer state encoding
// and the FFT-size to power-bin-count helper.
package mel_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCEPT   = 2'd1,
        DRAIN    = 2'd2,
        WAIT_OUT = 2'd3
    } mel_ctrl_state_t;

    // Power bins produced by a real FFT of n_fft points (DC through Nyquist).
    function automatic int mel_n_bins(input int n_fft);
        return n_fft / 2 + 1;
    endfunction

endpackage

// File: rtl/mel_frame_controller.sv
// Frame sequencer for the mel filterbank: streams bin indices into the filter
// array, waits out the filter latency, then captures energies into the output slot.
module mel_frame_controller
    import mel_pkg::*;
#(
    parameter int N_BINS       = mel_n_bins(512),
    parameter int FILT_LATENCY = 2,
    parameter int KW           = $clog2(N_BINS)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          power_valid_in,
    input  logic          power_last_in,
    output logic          power_ready_out,
    output logic          bin_valid_out,
    output logic [KW-1:0] bin_k_out,
    output logic          bin_clear_out,
    output logic          capture_out,
    output logic          filtered_valid_out,
    input  logic          filtered_ready_in,
    output logic          frame_error_out,
    output logic [15:0]   frame_count_out
);

    localparam int              DW         = $clog2(FILT_LATENCY + 2);
    localparam logic [KW-1:0]   K_LAST     = KW'(N_BINS - 1);
    localparam logic [DW-1:0]   DRAIN_LOAD = DW'(FILT_LATENCY);

    mel_ctrl_state_t state_reg;
    logic [KW-1:0]   k_reg;
    logic [DW-1:0]   drain_reg;
    logic            filtered_valid_reg;
    logic            frame_error_reg;
    logic [15:0]     frame_count_reg;

    logic handshake;
    logic k_at_last;
    logic frame_end;
    logic slot_free;
    logic capture;

    always_comb begin
        handshake = power_valid_in && (state_reg == ACCEPT);
        k_at_last = (k_reg == K_LAST);
        frame_end = power_last_in || k_at_last;
        slot_free = !filtered_valid_reg || filtered_ready_in;
        // Capture may coincide with the downstream accept of the previous frame.
        capture   = ((state_reg == DRAIN) && (drain_reg == '0) && slot_free) ||
                    ((state_reg == WAIT_OUT) && filtered_ready_in);
    end

    assign power_ready_out    = (state_reg == ACCEPT);
    assign bin_valid_out      = handshake;
    assign bin_k_out          = k_reg;
    assign bin_clear_out      = handshake && (k_reg == '0);
    assign capture_out        = capture;
    assign filtered_valid_out = filtered_valid_reg;
    assign frame_error_out    = frame_error_reg;
    assign frame_count_out    = frame_count_reg;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg          <= IDLE;
            k_reg              <= '0;
            drain_reg          <= '0;
            filtered_valid_reg <= 1'b0;
            frame_error_reg    <= 1'b0;
            frame_count_reg    <= '0;
        end else begin
            frame_error_reg <= 1'b0;

            if (capture) begin
                filtered_valid_reg <= 1'b1;
                frame_count_reg    <= frame_count_reg + 16'd1;
            end else if (filtered_ready_in) begin
                filtered_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: state_reg <= ACCEPT;
                ACCEPT: begin
                    if (handshake) begin
                        if (frame_end) begin
                            k_reg           <= '0;
                            drain_reg       <= DRAIN_LOAD;
                            state_reg       <= DRAIN;
                            // Mismatch between the last flag and the bin count is a length error.
                            frame_error_reg <= power_last_in ^ k_at_last;
                        end else begin
                            k_reg <= k_reg + KW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_reg != '0) begin
                        drain_reg <= drain_reg - DW'(1);
                    end else if (slot_free) begin
                        state_reg <= ACCEPT;
                    end else begin
                        state_reg <= WAIT_OUT;
                    end
                end
                WAIT_OUT: begin
                    if (filtered_ready_in) begin
                        state_reg <= ACCEPT;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mel_frame_controller.sv
// Directed bench for mel_frame_controller: one DUT at FILT_LATENCY=2 checked
// through a capture scoreboard, a second at FILT_LATENCY=0 for the no-stall case.
module tb_mel_frame_controller;

    localparam int N   = 8;
    localparam int LAT = 2;
    localparam int KW  = $clog2(N);

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic          rst_in;
    logic          power_valid_in, power_last_in, filtered_ready_in;
    logic          power_ready_out, bin_valid_out, bin_clear_out, capture_out;
    logic          filtered_valid_out, frame_error_out;
    logic [KW-1:0] bin_k_out;
    logic [15:0]   frame_count_out;

    logic          valid_z, last_z;
    logic          ready_z = 1'b1;
    logic          power_ready_z, bin_valid_z, bin_clear_z, capture_z;
    logic          filtered_valid_z, frame_error_z;
    logic [KW-1:0] bin_k_z;
    logic [15:0]   frame_count_z;

    mel_frame_controller #(.N_BINS(N), .FILT_LATENCY(LAT), .KW(KW)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .power_valid_in(power_valid_in), .power_last_in(power_last_in),
        .power_ready_out(power_ready_out), .bin_valid_out(bin_valid_out),
        .bin_k_out(bin_k_out), .bin_clear_out(bin_clear_out),
        .capture_out(capture_out), .filtered_valid_out(filtered_valid_out),
        .filtered_ready_in(filtered_ready_in), .frame_error_out(frame_error_out),
        .frame_count_out(frame_count_out)
    );

    mel_frame_controller #(.N_BINS(N), .FILT_LATENCY(0), .KW(KW)) dut_z (
        .clk_in(clk_in), .rst_in(rst_in),
        .power_valid_in(valid_z), .power_last_in(last_z),
        .power_ready_out(power_ready_z), .bin_valid_out(bin_valid_z),
        .bin_k_out(bin_k_z), .bin_clear_out(bin_clear_z),
        .capture_out(capture_z), .filtered_valid_out(filtered_valid_z),
        .filtered_ready_in(ready_z), .frame_error_out(frame_error_z),
        .frame_count_out(frame_count_z)
    );

    typedef struct {
        int          cycle;
        bit          chk_cycle;
        logic [15:0] count;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [15:0] exp_count = 16'd0;
    bit          rdy_g = 1'b1;
    bit          pend = 1'b0;
    logic [15:0] pend_count = 16'd0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v = 1'b0, input bit l = 1'b0,
                        input bit v0 = 1'b0, input bit l0 = 1'b0);
        @(negedge clk_in);
        power_valid_in    = v;
        power_last_in     = l;
        filtered_ready_in = rdy_g;
        valid_z           = v0;
        last_z            = l0;
        #1;
    endtask

    // Capture monitor: pops the scoreboard on every capture strobe.
    always @(negedge clk_in) begin
        exp_t e;
        #2;
        if (pend) begin
            check("post_capture_valid", 32'(filtered_valid_out), 32'd1);
            check("post_capture_count", 32'(frame_count_out), 32'(pend_count));
            pend = 1'b0;
        end
        if (rst_in === 1'b1 && capture_out === 1'b1) begin
            if (sb.size() == 0) begin
                check("capture_unexpected", 32'(capture_out), 32'd0);
            end else begin
                e = sb.pop_front();
                check("capture_count_before", 32'(frame_count_out), 32'(e.count - 16'd1));
                if (e.chk_cycle) check("capture_cycle", 32'(cyc), 32'(e.cycle));
                $display("capture: frame %0d at cycle %0d", e.count, cyc);
                pend       = 1'b1;
                pend_count = e.count;
            end
        end
    end

    // last_at >= N means the frame carries no last flag.
    task automatic send_frame(input int last_at, input bit gaps, input bit slot_free);
        bit ended = 1'b0;
        int i = 0;
        for (int n = 0; n < 20 && power_ready_out !== 1'b1; n++) step();
        check("ready_before_frame", 32'(power_ready_out), 32'd1);
        while (!ended && i < N) begin
            if (gaps && i > 0) begin
                step();
                check("gap_valid", 32'(bin_valid_out), 32'd0);
                check("gap_k", 32'(bin_k_out), 32'(i));
            end
            step(1'b1, i == last_at);
            check("bin_valid", 32'(bin_valid_out), 32'd1);
            check("bin_k", 32'(bin_k_out), 32'(i));
            check("bin_clear", 32'(bin_clear_out), 32'(i == 0));
            if (i == last_at || i == N - 1) begin
                exp_count++;
                sb.push_back('{cyc + 1 + LAT, slot_free, exp_count});
                ended = 1'b1;
            end
            i++;
        end
        step();
        check("frame_error", 32'(frame_error_out), 32'(last_at != N - 1));
        check("k_reset", 32'(bin_k_out), 32'd0);
        check("ready_in_drain", 32'(power_ready_out), 32'd0);
        step();
        check("frame_error_once", 32'(frame_error_out), 32'd0);
        $display("frame %0d sent: last_at=%0d gaps=%0d", exp_count, last_at, gaps);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 40 && sb.size() != 0; n++) step();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b0;
        power_valid_in = 1'b0; power_last_in = 1'b0; filtered_ready_in = 1'b1;
        valid_z = 1'b0; last_z = 1'b0;
        repeat (2) @(negedge clk_in);
        #1;
        check("rst_ready", 32'(power_ready_out), 32'd0);
        check("rst_fvalid", 32'(filtered_valid_out), 32'd0);
        check("rst_count", 32'(frame_count_out), 32'd0);
        check("rst_error", 32'(frame_error_out), 32'd0);
        check("rst_k", 32'(bin_k_out), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check("idle_ready", 32'(power_ready_out), 32'd0);
        step();
        check("first_ready", 32'(power_ready_out), 32'd1);

        // Nominal frame, downstream always ready.
        send_frame(N - 1, 1'b0, 1'b1);
        wait_drain();
        check("A_ready_after", 32'(power_ready_out), 32'd1);
        check("A_fvalid_after", 32'(filtered_valid_out), 32'd1);
        step();
        check("A_fvalid_drop", 32'(filtered_valid_out), 32'd0);

        // Short frame then long frame: both are length errors.
        send_frame(4, 1'b0, 1'b1);
        wait_drain();
        send_frame(99, 1'b0, 1'b1);
        wait_drain();

        // Bubbles between bins.
        send_frame(N - 1, 1'b1, 1'b1);
        wait_drain();

        // Downstream stalled: first frame captures into a free slot, second waits.
        rdy_g = 1'b0;
        send_frame(N - 1, 1'b0, 1'b1);
        wait_drain();
        check("E_fvalid_held", 32'(filtered_valid_out), 32'd1);
        send_frame(N - 1, 1'b0, 1'b0);
        for (int n = 0; n < 8; n++) begin
            step();
            check("F_wait_ready", 32'(power_ready_out), 32'd0);
            check("F_wait_capture", 32'(capture_out), 32'd0);
        end
        rdy_g = 1'b1;
        step();
        check("F_capture_on_ready", 32'(capture_out), 32'd1);
        rdy_g = 1'b0;
        step();
        check("F_fvalid_kept", 32'(filtered_valid_out), 32'd1);
        check("F_ready_back", 32'(power_ready_out), 32'd1);
        check("F_count", 32'(frame_count_out), 32'd6);
        check("F_sb_empty", 32'(sb.size()), 32'd0);

        // Zero filter latency on the second instance.
        check("Z_ready", 32'(power_ready_z), 32'd1);
        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b0, 1'b1, i == N - 1);
            check("Z_bin_k", 32'(bin_k_z), 32'(i));
        end
        step();
        check("Z_capture", 32'(capture_z), 32'd1);
        check("Z_ready_drain", 32'(power_ready_z), 32'd0);
        step();
        check("Z_capture_once", 32'(capture_z), 32'd0);
        check("Z_ready_again", 32'(power_ready_z), 32'd1);
        check("Z_fvalid", 32'(filtered_valid_z), 32'd1);
        check("Z_count", 32'(frame_count_z), 32'd1);
        $display("zero-latency frame done: count=%0d", frame_count_z);

        // Reset in the middle of a frame while an output is pending.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("M_k3", 32'(bin_k_out), 32'd3);
        check("M_fvalid_pending", 32'(filtered_valid_out), 32'd1);
        rst_in = 1'b0;
        #1;
        check("M_rst_fvalid", 32'(filtered_valid_out), 32'd0);
        check("M_rst_count", 32'(frame_count_out), 32'd0);
        check("M_rst_ready", 32'(power_ready_out), 32'd0);
        check("M_rst_k", 32'(bin_k_out), 32'd0);
        check("M_rst_bin_valid", 32'(bin_valid_out), 32'd0);
        check("M_rst_capture", 32'(capture_out), 32'd0);
        step();
        @(negedge clk_in);
        rst_in = 1'b1;
        rdy_g = 1'b1;
        power_valid_in = 1'b1;
        filtered_ready_in = 1'b1;
        #1;
        check("M_idle_ready", 32'(power_ready_out), 32'd0);
        check("M_idle_bin_valid", 32'(bin_valid_out), 32'd0);
        exp_count = 16'd0;
        send_frame(N - 1, 1'b0, 1'b1);
        wait_drain();
        check("M_count_after", 32'(frame_count_out), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mel_frame_controller.md
# mel_frame_controller

Sequencer for the mel filterbank in the biometrics feature extractor. Accepts one power-spectrum frame per handshake burst, drives the per-bin index and frame-clear strobe into the triangular filter array, and waits out the filter pipeline latency. It then pulses a capture strobe so the filterbank energies are latched into the output register, and presents them downstream with valid/ready backpressure. Upstream is stalled only while a finished frame cannot yet be captured.

## Interface
Parameters:
- N_BINS, 257: power bins per frame (N_FFT/2+1); must be ≥2.
- FILT_LATENCY, 2: cycles from the last bin handshake until filter accumulators are stable; may be 0.
- KW, $clog2(N_BINS): width of the bin index.

Ports:
- clk_in, input, 1: single clock; all logic is rising-edge.
- rst_in, input, 1: reset, asynchronous, active-low.
- power_valid_in, input, 1: upstream bin valid.
- power_last_in, input, 1: upstream marks the final bin of the frame.
- power_ready_out, output, 1: controller accepts a bin.
- bin_valid_out, output, 1: filterbank must process the current bin (= power_valid_in & power_ready_out).
- bin_k_out, output, KW: index of the current bin.
- bin_clear_out, output, 1: high with bin_valid_out when bin_k_out==0; filters restart accumulation.
- capture_out, output, 1: one-cycle strobe; the output register latches the filterbank energies.
- filtered_valid_out, output, 1: latched energies are valid downstream.
- filtered_ready_in, input, 1: downstream accepts the energies.
- frame_error_out, output, 1: one-cycle pulse on a frame-length violation.
- frame_count_out, output, 16: number of frames captured since reset; wraps.

## Operation
- States: IDLE, ACCEPT, DRAIN, WAIT_OUT.
- Reset state is IDLE, with k=0, drain counter=0, filtered_valid_out=0, frame_error_out=0, frame_count_out=0.
- IDLE: power_ready_out=0. Moves to ACCEPT on the next edge unconditionally.
- ACCEPT: power_ready_out=1. On each handshake, k increments.
  - End of frame is a handshake with power_last_in=1 or k==N_BINS-1, whichever occurs first. On end of frame: k←0, drain counter←FILT_LATENCY, go to DRAIN.
  - Short frame: power_last_in=1 with k<N_BINS-1. Long frame: k==N_BINS-1 with power_last_in=0. Either case ends the frame as above and pulses frame_error_out.
- DRAIN: power_ready_out=0. The counter decrements while nonzero.
  - When the counter reads 0 and the output slot is free (!filtered_valid_out or filtered_ready_in), assert capture_out and go to ACCEPT.
  - When the counter reads 0 and the slot is occupied, go to WAIT_OUT.
- WAIT_OUT: power_ready_out=0. When filtered_ready_in=1, assert capture_out that cycle and go to ACCEPT.
- Capture: filtered_valid_out←1 and frame_count_out←frame_count_out+1 (mod 2^16) on the edge ending the capture_out cycle.
- Downstream: filtered_valid_out falls on an edge where filtered_ready_in=1 and capture_out=0.
  - If a capture and a downstream accept fall in the same cycle, filtered_valid_out stays 1 and now holds the new frame.
- Output double-buffering: the next frame streams into the filters while the previous result is held in the output register. The filter accumulators are not cleared at capture; bin_clear_out on bin 0 of the next frame clears them.
- Reset mid-frame: everything returns to reset values immediately and asynchronously. A pending output is dropped and a partial frame is discarded. The first bin after reset carries bin_clear_out.

## Timing
- bin_valid_out, bin_k_out and bin_clear_out are combinational from inputs and state (zero latency). All other outputs are registered.
- A last-bin handshake at edge t puts the controller in DRAIN for cycles t+1 … t+1+FILT_LATENCY.
  - capture_out is high in cycle t+1+FILT_LATENCY if the output slot is free.
  - filtered_valid_out and power_ready_out are both high from cycle t+2+FILT_LATENCY.
- Minimum frame period: N_BINS+FILT_LATENCY+1 cycles.
- frame_error_out is high in the cycle after the offending handshake.
- After rst_in deasserts, power_ready_out first rises in the second cycle (the first cycle is spent in IDLE).

## Structure
- Shared package mel_pkg holds the state enum mel_ctrl_state_t and a helper function for the N_BINS computation; the filterbank and the feature-extractor top import it.
- No sub-module. A flat FSM plus bin counter, drain counter and frame counter.

## Test plan
- N_BINS=8, FILT_LATENCY=2, continuous valid, ready_in=1: bin_k_out runs 0..7, bin_clear_out only at k=0, capture_out 3 cycles after bin 7, filtered_valid_out 1 cycle later, frame_count_out=1.
- Short frame, power_last_in at k=4: frame_error_out pulses once, k returns to 0, capture still occurs. Long frame, no last by k=7: error pulse, frame ends at k=7.
- ready_in held 0 across two frames: the second frame enters WAIT_OUT with power_ready_out=0. Raising ready_in for one cycle gives capture_out in that same cycle, filtered_valid_out stays 1, and frame_count_out=2.
- FILT_LATENCY=0: capture_out in the cycle after the last handshake, no extra stall.
- Bubbles: power_valid_in toggled 1/0: bin_k_out advances only on handshakes, and bin_valid_out=0 in gaps.
- rst_in low at k=3 with filtered_valid_out=1: all outputs clear at once, IDLE for one cycle after release, and the next frame starts at k=0 with bin_clear_out.
